// File: rtl/led_drv_pkg.sv
// Shared register map and STATUS layout for the LED PWM/blink driver.
package led_drv_pkg;

  localparam logic [1:0] ADDR_DUTY       = 2'd0;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
  localparam logic [1:0] ADDR_BLINK_HALF = 2'd2;
  localparam logic [1:0] ADDR_STATUS     = 2'd3;

  localparam int STATUS_PHASE_BIT = 16;
  localparam int STATUS_PWM_LSB   = 0;

endpackage

// File: rtl/led_pwm_blink_driver_if.sv
// Avalon-MM slave bundle used to configure the LED driver from the Nios data bus.
interface led_pwm_blink_driver_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/led_pwm_blink_driver_timebase.sv
// Prescaled PWM timebase: a free-running PWM counter advanced once every PRESCALE clocks.
module led_pwm_timebase #(
  parameter int PRESCALE = 50,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_wrap
);

  // A 1-bit prescaler is kept even for PRESCALE=1 so tick is simply always true.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick     = (pre_cnt == PRE_MAX);
  assign pwm_wrap = tick & (&pwm_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pwm_blink_driver.sv
// LED pin driver behind the PIO: global PWM dimming plus per-LED blinking, configured over Avalon-MM.
module led_pwm_blink_driver
  import led_drv_pkg::*;
#(
  parameter int N_LEDS     = 10,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 50,
  parameter int BLINK_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_LEDS-1:0]     led_in,
  output logic [N_LEDS-1:0]     led_out,
  led_pwm_blink_driver_if.slave bus
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [PWM_BITS-1:0]   duty;
  logic [N_LEDS-1:0]     blink_mask;
  logic [BLINK_BITS-1:0] blink_half;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  blink_phase;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  pwm_wrap;
  logic                  pwm_on;
  logic                  wr_en;

  led_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk      (clk),
    .reset_n  (reset_n),
    .pwm_cnt  (pwm_cnt),
    .pwm_wrap (pwm_wrap)
  );

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Full-scale duty bypasses the compare so there is no dark tick at pwm_cnt==max.
  assign pwm_on = (duty == DUTY_MAX) | (pwm_cnt < duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty       <= DUTY_MAX;
      blink_mask <= '0;
      blink_half <= '0;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DUTY:       duty       <= bus.writedata[PWM_BITS-1:0];
        ADDR_BLINK_MASK: blink_mask <= bus.writedata[N_LEDS-1:0];
        ADDR_BLINK_HALF: blink_half <= bus.writedata[BLINK_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DUTY:       bus.readdata[PWM_BITS-1:0]   = duty;
      ADDR_BLINK_MASK: bus.readdata[N_LEDS-1:0]     = blink_mask;
      ADDR_BLINK_HALF: bus.readdata[BLINK_BITS-1:0] = blink_half;
      ADDR_STATUS: begin
        bus.readdata[STATUS_PHASE_BIT]             = blink_phase;
        bus.readdata[STATUS_PWM_LSB +: PWM_BITS]   = pwm_cnt;
      end
      default: ;
    endcase
  end

  // Rewriting the half-period restarts the blink in its lit phase, even over a coincident wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_en && (bus.address == ADDR_BLINK_HALF)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_half == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (pwm_wrap) begin
      if (blink_cnt == blink_half - 1'b1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= led_in & {N_LEDS{pwm_on}} & (~blink_mask | {N_LEDS{blink_phase}});
    end
  end

endmodule
